// File: rtl/xfcp_uart_tx_if.sv
// AXI-stream byte channel feeding the XFCP host-side UART transmitter.
interface xfcp_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/xfcp_uart_tx.sv
// Host-side UART transmitter: serialises AXI-stream words into start/data/parity/stop
// frames on txd, with a bit period of max(prescale,1)*8 clocks latched per frame.
module xfcp_uart_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    xfcp_uart_tx_if.slave       s_axis,
    input  logic [15:0]         prescale,
    output logic                txd,
    output logic                busy
);

    localparam int unsigned CNT_W = 19;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  txd_q, txd_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic [15:0]           ps_eff_c;
    logic [CNT_W-1:0]      period_c;
    logic                  par_c;

    // Bit period minus one: (max(prescale,1) * 8) - 1, built without a multiplier.
    assign ps_eff_c = (prescale == 16'd0) ? 16'd1 : prescale;
    assign period_c = {ps_eff_c - 16'd1, 3'b111};
    assign par_c    = (PARITY == 1) ? ~^data_q : ^data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            data_q   <= '0;
            shreg_q  <= '0;
            idx_q    <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            data_q   <= data_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        data_d   = data_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
                // Start bit is driven on the handshake edge itself.
                if (s_axis.tvalid && ready_q) begin
                    data_d   = s_axis.tdata;
                    shreg_d  = s_axis.tdata;
                    period_d = period_c;
                    cnt_d    = period_c;
                    idx_d    = '0;
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = period_q;
                    txd_d   = shreg_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = period_q;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            txd_d   = par_c;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                        txd_d   = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = period_q;
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Each stop bit reloads the timer so the 19-bit counter never overflows.
                if (cnt_q == '0) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = period_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign txd           = txd_q;
    assign busy          = busy_q;
    assign s_axis.tready = ready_q;

endmodule

// File: tb/tb_xfcp_uart_tx.sv
// Scoreboard bench for xfcp_uart_tx: four parameterisations share clock, reset and prescale.
module tb_xfcp_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] prescale;
    logic [3:0]  txd;
    logic [3:0]  busy;
    logic [3:0]  rdy;
    int          cyc = 0;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];

    xfcp_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
    xfcp_uart_tx_if #(.DATA_WIDTH(8)) if1 ();
    xfcp_uart_tx_if #(.DATA_WIDTH(8)) if2 ();
    xfcp_uart_tx_if #(.DATA_WIDTH(8)) if3 ();

    // 0: no parity/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: even/2 stop
    xfcp_uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(if0.slave), .prescale(prescale), .txd(txd[0]), .busy(busy[0]));
    xfcp_uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(if1.slave), .prescale(prescale), .txd(txd[1]), .busy(busy[1]));
    xfcp_uart_tx #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis(if2.slave), .prescale(prescale), .txd(txd[2]), .busy(busy[2]));
    xfcp_uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_axis(if3.slave), .prescale(prescale), .txd(txd[3]), .busy(busy[3]));

    assign rdy = {if3.tready, if2.tready, if1.tready, if0.tready};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_in(input int d, input logic v, input logic [7:0] dat);
        case (d)
            0: begin if0.tvalid = v; if0.tdata = dat; end
            1: begin if1.tvalid = v; if1.tdata = dat; end
            2: begin if2.tvalid = v; if2.tdata = dat; end
            default: begin if3.tvalid = v; if3.tdata = dat; end
        endcase
    endtask

    // Present a word and return at the falling edge after the accepting rising edge.
    task automatic handshake(input int d, input logic [7:0] dat, output int hs_cyc, output bit to);
        set_in(d, 1'b1, dat);
        to = 1'b1;
        hs_cyc = 0;
        for (int n = 0; n < 4000; n++) begin
            if (rdy[d]) begin
                @(posedge clk);
                @(negedge clk);
                hs_cyc = cyc;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Decode one frame by sampling the middle of every bit.
    task automatic capture_frame(input int d, input int p, input bit has_par, input int nstop,
                                 output logic [7:0] dat, output logic par, output bit frame_ok,
                                 output int start_cyc, output bit to);
        dat = '0;
        par = 1'b0;
        frame_ok = 1'b1;
        start_cyc = 0;
        to = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (txd[d] == 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) begin
            start_cyc = cyc;
            repeat (p / 2) @(negedge clk);
            if (txd[d] !== 1'b0) frame_ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (p) @(negedge clk);
                dat[3'(k)] = txd[d];
            end
            if (has_par) begin
                repeat (p) @(negedge clk);
                par = txd[d];
            end
            for (int k = 0; k < nstop; k++) begin
                repeat (p) @(negedge clk);
                if (txd[d] !== 1'b1) frame_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (txd[d] !== 1'b1 || rdy[d] !== 1'b0 || busy[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold dut%0d got txd=%b tready=%b busy=%b exp 1 0 0", d, txd[d], rdy[d], busy[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (txd[d] !== 1'b1 || rdy[d] !== 1'b1 || busy[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release dut%0d got txd=%b tready=%b busy=%b exp 1 1 0", d, txd[d], rdy[d], busy[d]);
            end
        end
    endtask

    // Cycle-exact waveform of a no-parity frame on dut0; optional prescale change mid-frame.
    task automatic test_waveform(input string name, input logic [15:0] ps, input logic [7:0] dat, input bit poke);
        int hs;
        bit to;
        logic exp_b;
        logic [7:0] dec;
        logic [7:0] e;
        dec = '0;
        prescale = ps;
        exp_q.push_back(dat);
        handshake(0, dat, hs, to);
        set_in(0, 1'b0, dat);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s_handshake got timeout exp accept", name);
            return;
        end
        for (int i = 0; i <= 80; i++) begin
            if (i > 0) @(negedge clk);
            if (poke && i == 20) prescale = 16'd5;
            if (i < 80) begin
                if (i < 8)       exp_b = 1'b0;
                else if (i < 72) exp_b = dat[3'((i / 8) - 1)];
                else             exp_b = 1'b1;
                if (i >= 8 && i < 72 && (i % 8) == 4) dec[3'((i / 8) - 1)] = txd[0];
                vectors++;
                if (txd[0] !== exp_b || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_cycle%0d got txd=%b busy=%b tready=%b exp %b 1 0", name, i, txd[0], busy[0], rdy[0], exp_b);
                end
            end else begin
                vectors++;
                if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_end got txd=%b busy=%b tready=%b exp 1 0 1", name, txd[0], busy[0], rdy[0]);
                end
            end
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s_data got 0x%0h exp scoreboard entry", name, dec);
        end else begin
            e = exp_q.pop_front();
            if (dec !== e) begin
                miscompares++;
                $display("FAIL %s_data got 0x%0h exp 0x%0h", name, dec, e);
            end
        end
        prescale = 16'd1;
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, s1, s2;
        bit to1, to2, tm1, tm2, ok1, ok2;
        logic [7:0] d1, d2, e;
        logic p1, p2;
        logic [7:0] dec[2];
        prescale = 16'd2;
        @(negedge clk);
        fork
            begin
                exp_q.push_back(8'hA3);
                handshake(0, 8'hA3, hs1, to1);
                exp_q.push_back(8'h0F);
                handshake(0, 8'h0F, hs2, to2);
                set_in(0, 1'b0, 8'h0F);
            end
            begin
                capture_frame(0, 16, 1'b0, 1, d1, p1, ok1, s1, tm1);
                capture_frame(0, 16, 1'b0, 1, d2, p2, ok2, s2, tm2);
            end
        join
        dec[0] = d1;
        dec[1] = d2;
        vectors++;
        if (to1 || to2 || tm1 || tm2) begin
            miscompares++;
            $display("FAIL b2b_timeout got hs=%b%b mon=%b%b exp 0000", to1, to2, tm1, tm2);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_data%0d got 0x%0h exp scoreboard entry", k, dec[k]);
            end else begin
                e = exp_q.pop_front();
                if (dec[k] !== e) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d got 0x%0h exp 0x%0h", k, dec[k], e);
                end
            end
        end
        vectors++;
        if (!ok1 || !ok2) begin
            miscompares++;
            $display("FAIL b2b_framing got ok=%b%b exp 11", ok1, ok2);
        end
        vectors++;
        if (s2 - s1 != 161 || hs2 - hs1 != 161) begin
            miscompares++;
            $display("FAIL b2b_spacing got start=%0d hs=%0d exp 161", s2 - s1, hs2 - hs1);
        end
        vectors++;
        if (s1 != hs1) begin
            miscompares++;
            $display("FAIL b2b_start_edge got start=%0d hs=%0d exp equal", s1, hs1);
        end
        prescale = 16'd1;
    endtask

    task automatic test_parity();
        int hs, len, st, nstop, len_exp;
        bit to, tm, ok;
        logic [7:0] dat, e;
        logic par, par_exp;
        logic [7:0] word;
        prescale = 16'd1;
        word = 8'h07;
        for (int d = 1; d < 4; d++) begin
            nstop   = (d == 3) ? 2 : 1;
            len_exp = (1 + 8 + 1 + nstop) * 8;
            par_exp = (d == 2) ? ~^word : ^word;
            len = 0;
            @(negedge clk);
            exp_q.push_back(word);
            fork
                begin
                    handshake(d, word, hs, to);
                    set_in(d, 1'b0, word);
                    for (int n = 0; n < 2000; n++) begin
                        if (rdy[d]) break;
                        @(negedge clk);
                    end
                    len = cyc - hs;
                end
                begin
                    capture_frame(d, 8, 1'b1, nstop, dat, par, ok, st, tm);
                end
            join
            vectors++;
            if (to || tm || !ok) begin
                miscompares++;
                $display("FAIL parity_frame dut%0d got hs_to=%b mon_to=%b ok=%b exp 0 0 1", d, to, tm, ok);
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL parity_data dut%0d got 0x%0h exp scoreboard entry", d, dat);
            end else begin
                e = exp_q.pop_front();
                if (dat !== e) begin
                    miscompares++;
                    $display("FAIL parity_data dut%0d got 0x%0h exp 0x%0h", d, dat, e);
                end
            end
            vectors++;
            if (par !== par_exp) begin
                miscompares++;
                $display("FAIL parity_bit dut%0d got %b exp %b", d, par, par_exp);
            end
            vectors++;
            if (len != len_exp) begin
                miscompares++;
                $display("FAIL parity_len dut%0d got %0d exp %0d", d, len, len_exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int hs, st;
        bit to, tm, ok, stuck;
        logic [7:0] dat, e;
        logic par;
        prescale = 16'd1;
        @(negedge clk);
        handshake(0, 8'h00, hs, to);
        set_in(0, 1'b0, 8'h00);
        repeat (35) @(negedge clk);
        vectors++;
        if (to || txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_bit3 got to=%b txd=%b busy=%b exp 0 0 1", to, txd[0], busy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async got txd=%b busy=%b tready=%b exp 1 0 0", txd[0], busy[0], rdy[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy[0] !== 1'b1 || busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_release got tready=%b busy=%b txd=%b exp 1 0 1", rdy[0], busy[0], txd[0]);
        end
        stuck = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) stuck = 1'b1;
        end
        vectors++;
        if (stuck) begin
            miscompares++;
            $display("FAIL rstmid_no_resume got activity exp idle line");
        end
        exp_q.push_back(8'h3C);
        fork
            begin
                handshake(0, 8'h3C, hs, to);
                set_in(0, 1'b0, 8'h3C);
            end
            begin
                capture_frame(0, 8, 1'b0, 1, dat, par, ok, st, tm);
            end
        join
        vectors++;
        if (to || tm || !ok || st != hs) begin
            miscompares++;
            $display("FAIL rstmid_frame got hs_to=%b mon_to=%b ok=%b start-hs=%0d exp 0 0 1 0", to, tm, ok, st - hs);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rstmid_data got 0x%0h exp scoreboard entry", dat);
        end else begin
            e = exp_q.pop_front();
            if (dat !== e) begin
                miscompares++;
                $display("FAIL rstmid_data got 0x%0h exp 0x%0h", dat, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        prescale = 16'd1;
        for (int d = 0; d < 4; d++) set_in(d, 1'b0, 8'h00);
        #1 rst_n = 1'b0;

        test_reset();
        test_waveform("single55", 16'd1, 8'h55, 1'b0);
        test_back_to_back();
        test_parity();
        test_waveform("ps0_ff", 16'd0, 8'hFF, 1'b1);
        test_reset_mid_frame();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
